// File: rtl/synth_pkg.sv
// Shared types and helpers for the time-multiplexed voice divider.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package synth_pkg;

   // Width of the per-voice divide value and counter held in the state array.
   localparam int SYNTH_WIDTH = 16;

   // Index width for n slots, never narrower than one bit.
   function automatic int clog2_min1(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

   // Per-voice state: enable, divide value and running service counter.
   typedef struct packed {
      logic                   en;
      logic [SYNTH_WIDTH-1:0] div;
      logic [SYNTH_WIDTH-1:0] cnt;
   } voice_state_t;

endpackage

// File: rtl/voice_state_ram.sv
// Flop array holding every voice's state; async read by slot, one write per entry per clock.
// Latency: read is combinational, write lands at the next edge.
// Backpressure: none; a config write overrides the service update for the same entry.
module voice_state_ram
   import synth_pkg::*;
#(
   parameter int VOICES = 4,
   parameter int VW     = 2
)(
   input  logic         clk,
   input  logic         rst_n,
   input  logic [VW-1:0] i_rd_idx,
   output voice_state_t  o_rd_dat,
   input  logic          i_svc_we,
   input  logic [VW-1:0] i_svc_idx,
   input  voice_state_t  i_svc_dat,
   input  logic          i_cfg_we,
   input  logic [VW-1:0] i_cfg_idx,
   input  voice_state_t  i_cfg_dat
);

   voice_state_t r_mem [VOICES];

   // Combinational read so the engine can compute next state in the same cycle.
   assign o_rd_dat = r_mem[i_rd_idx];

   // Per-entry write select; config beats service. Indices past VOICES-1 hit no entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < VOICES; i++) r_mem[i] <= '0;
      end else begin
         for (int i = 0; i < VOICES; i++) begin
            if (i_cfg_we && (i_cfg_idx == VW'(i))) begin
               r_mem[i] <= i_cfg_dat;
            end else if (i_svc_we && (i_svc_idx == VW'(i))) begin
               r_mem[i] <= i_svc_dat;
            end
         end
      end
   end

endmodule

// File: rtl/voice_div_sched.sv
// Round-robin divider: one increment/compare engine serves VOICES slots, s_out[v] = clk/(VOICES*div[v]).
// Latency: config write and service update both land at the edge ending the cycle.
// Backpressure: none; writes always accepted, a write to the slot being serviced skips that service.
module voice_div_sched
   import synth_pkg::*;
#(
   parameter  int VOICES = 4,
   parameter  int WIDTH  = SYNTH_WIDTH,
   localparam int VW     = clog2_min1(VOICES)
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [VW-1:0]     cfg_voice,
   input  logic [WIDTH-1:0]  cfg_div,
   input  logic              cfg_en,
   output logic [VOICES-1:0] s_out,
   output logic [VW-1:0]     slot,
   output logic              frame
);

   // State fields are sized by the package; WIDTH is expected to match it.
   localparam int SW = SYNTH_WIDTH;

   logic [VW-1:0]     r_slot;
   logic              r_frame;
   logic [VOICES-1:0] r_s_out;

   logic [VW-1:0]     w_slot_nxt;
   voice_state_t      w_rd;
   voice_state_t      w_svc_dat;
   voice_state_t      w_cfg_dat;
   logic              w_active;
   logic [SW:0]       w_sum;
   logic [SW-1:0]     w_cnt_n;
   logic              w_svc_out;

   assign w_slot_nxt = (r_slot == VW'(VOICES - 1)) ? '0 : r_slot + VW'(1);

   // Slot pointer runs free; frame is registered alongside it so it marks slot 0 glitch-free.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot  <= '0;
         r_frame <= 1'b1;
      end else begin
         r_slot  <= w_slot_nxt;
         r_frame <= (w_slot_nxt == '0);
      end
   end

   voice_state_ram #(
      .VOICES (VOICES),
      .VW     (VW)
   ) u_ram (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_rd_idx  (r_slot),
      .o_rd_dat  (w_rd),
      .i_svc_we  (1'b1),
      .i_svc_idx (r_slot),
      .i_svc_dat (w_svc_dat),
      .i_cfg_we  (cfg_we),
      .i_cfg_idx (cfg_voice),
      .i_cfg_dat (w_cfg_dat)
   );

   // Shared engine: increment one bit wider than the counter, wrap at div, compare against div/2.
   always_comb begin
      w_active      = w_rd.en && (w_rd.div >= SW'(2));
      w_sum         = {1'b0, w_rd.cnt} + {{SW{1'b0}}, 1'b1};
      w_cnt_n       = (w_sum == {1'b0, w_rd.div}) ? '0 : w_sum[SW-1:0];
      w_svc_out     = w_active && (w_cnt_n >= (w_rd.div >> 1));
      w_svc_dat     = w_rd;
      w_svc_dat.cnt = w_active ? w_cnt_n : '0;
      w_cfg_dat     = '0;
      w_cfg_dat.en  = cfg_en;
      w_cfg_dat.div = cfg_div;
   end

   // Output vector: a write clears its voice, otherwise only the serviced voice updates.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s_out <= '0;
      end else begin
         for (int v = 0; v < VOICES; v++) begin
            if (cfg_we && (cfg_voice == VW'(v))) begin
               r_s_out[v] <= 1'b0;
            end else if (r_slot == VW'(v)) begin
               r_s_out[v] <= w_svc_out;
            end
         end
      end
   end

   assign s_out = r_s_out;
   assign slot  = r_slot;
   assign frame = r_frame;

endmodule

// File: tb/tb_voice_div_sched.sv
// Directed bench for voice_div_sched: reset, even/odd divides, mute, collision, mixed voices, async reset.
// Expected outputs come from hand-tabulated per-divide service patterns.
// Inputs are driven 1 time unit after each posedge and outputs sampled at the same point.
module tb_voice_div_sched;
   import synth_pkg::*;

   localparam int VOICES = 4;
   localparam int WIDTH  = 16;
   localparam int VW     = 2;

   logic              clk       = 1'b0;
   logic              rst_n     = 1'b0;
   logic              cfg_we    = 1'b0;
   logic [VW-1:0]     cfg_voice = '0;
   logic [WIDTH-1:0]  cfg_div   = '0;
   logic              cfg_en    = 1'b0;
   logic [VOICES-1:0] s_out;
   logic [VW-1:0]     slot;
   logic              frame;

   always #5 clk = ~clk;

   voice_div_sched #(.VOICES(VOICES), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_we    (cfg_we),
      .cfg_voice (cfg_voice),
      .cfg_div   (cfg_div),
      .cfg_en    (cfg_en),
      .s_out     (s_out),
      .slot      (slot),
      .frame     (frame)
   );

   int n_vec = 0;
   int n_err = 0;

   // Expected state per voice: programmed div/en, services since the last write, current output.
   int                m_div [VOICES];
   logic              m_en  [VOICES];
   int                m_k   [VOICES];
   logic [VOICES-1:0] m_out;
   int                m_slot;

   // Output after the k-th service following a write, indexed by k mod div (bit i = value at k%div==i).
   logic [1:0] pat2 = 2'b10;
   logic [2:0] pat3 = 3'b110;
   logic [3:0] pat4 = 4'b1100;
   logic [4:0] pat5 = 5'b11100;

   function automatic logic exp_bit(input int div, input int k);
      case (div)
         2:       return pat2[k % 2];
         3:       return pat3[k % 3];
         4:       return pat4[k % 4];
         5:       return pat5[k % 5];
         65535:   return (k % 65535) >= 32767;
         default: return 1'b0;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < VOICES; i++) begin
         m_div[i] = 0;
         m_en[i]  = 1'b0;
         m_k[i]   = 0;
      end
      m_out  = '0;
      m_slot = 0;
   endtask

   // One clock with an optional config write, then compare all outputs.
   task automatic step(input logic we, input int v, input int div, input logic en);
      cfg_we    = we;
      cfg_voice = VW'(v);
      cfg_div   = WIDTH'(div);
      cfg_en    = en;
      @(posedge clk);
      #1;
      cfg_we = 1'b0;
      for (int i = 0; i < VOICES; i++) begin
         if (we && (v == i)) begin
            m_div[i] = div;
            m_en[i]  = en;
            m_k[i]   = 0;
            m_out[i] = 1'b0;
         end else if (m_slot == i) begin
            if (m_en[i] && (m_div[i] >= 2)) begin
               m_k[i]++;
               m_out[i] = exp_bit(m_div[i], m_k[i]);
            end else begin
               m_k[i]   = 0;
               m_out[i] = 1'b0;
            end
         end
      end
      m_slot = (m_slot + 1) % VOICES;
      chk("s_out", 32'(s_out), 32'(m_out));
      chk("slot",  32'(slot),  32'(m_slot));
      chk("frame", 32'(frame), 32'(m_slot == 0));
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 0, 0, 1'b0);
   endtask

   task automatic idle_until_slot(input int s);
      int g;
      g = 0;
      while ((m_slot != s) && (g < VOICES)) begin
         idle(1);
         g++;
      end
   endtask

   initial begin
      // Reset held for three edges.
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst_s_out", 32'(s_out), 32'd0);
      chk("rst_slot",  32'(slot),  32'd0);
      chk("rst_frame", 32'(frame), 32'd1);
      rst_n = 1'b1;
      idle(5);

      // Even divide on voice 0.
      step(1'b1, 0, 4, 1'b1);
      idle(24);

      // Odd divide on voice 2, then mute with div=1 and div=0.
      step(1'b1, 2, 3, 1'b1);
      idle(24);
      begin
         int g;
         g = 0;
         while (!m_out[2] && (g < 12)) begin
            idle(1);
            g++;
         end
      end
      chk("v2_high_before_mute", 32'(s_out[2]), 32'd1);
      step(1'b1, 2, 1, 1'b1);
      chk("v2_div1_mute", 32'(s_out[2]), 32'd0);
      idle(8);
      step(1'b1, 2, 0, 1'b1);
      idle(8);

      // Collision: rewrite voice 1 in its own service cycle while it is high.
      step(1'b1, 1, 4, 1'b1);
      begin
         int g;
         g = 0;
         while ((m_k[1] < 2) && (g < 12)) begin
            idle(1);
            g++;
         end
      end
      idle_until_slot(1);
      chk("coll_pre_high", 32'(s_out[1]), 32'd1);
      step(1'b1, 1, 4, 1'b1);
      chk("coll_mute", 32'(s_out[1]), 32'd0);
      idle(24);

      // Mixed voices, then disable voice 1.
      idle_until_slot(1);
      step(1'b1, 0, 2, 1'b1);
      step(1'b1, 1, 5, 1'b1);
      step(1'b1, 2, 65535, 1'b1);
      step(1'b1, 3, 4, 1'b1);
      idle(44);
      step(1'b1, 1, 5, 1'b0);
      chk("v1_disable", 32'(s_out[1]), 32'd0);
      idle(24);

      // Asynchronous reset between edges while voices run.
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_s_out", 32'(s_out), 32'd0);
      chk("arst_slot",  32'(slot),  32'd0);
      chk("arst_frame", 32'(frame), 32'd1);
      model_reset();
      @(posedge clk);
      #4;
      rst_n = 1'b1;
      idle(16);
      step(1'b1, 3, 2, 1'b1);
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
